// File: rtl/h3_hash_pipe.sv
// H3 hash pipeline: NUM_HASH XOR-matrix hashes of one key, BITS_PER_STAGE key bits folded per stage.
// Latency NUM_STAGES cycles from acceptance, one key per cycle; Q matrix writable only while idle.
// Whole pipe stalls when last stage is full and out_ready is low. Define H3_HASH_CFG_READBACK_EN for cfg_re/cfg_rdata.
module h3_hash_pipe #(
   parameter int KEY_WIDTH      = 32,
   parameter int INDEX_WIDTH    = 12,
   parameter int NUM_HASH       = 2,
   parameter int BITS_PER_STAGE = 8,
   localparam int NUM_STAGES    = KEY_WIDTH / BITS_PER_STAGE,
   localparam int HASH_AW       = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1,
   // one extra bit for power-of-two key widths so out-of-range rows are addressable
   localparam int BIT_AW        = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH + 1) : 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [KEY_WIDTH-1:0]            in_key,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_HASH*INDEX_WIDTH-1:0] out_hash,
   input  logic                            cfg_we,
   input  logic [HASH_AW-1:0]              cfg_hash,
   input  logic [BIT_AW-1:0]               cfg_bit,
   input  logic [INDEX_WIDTH-1:0]          cfg_wdata,
   output logic                            cfg_ready
`ifdef H3_HASH_CFG_READBACK_EN
   ,
   input  logic                            cfg_re,
   output logic [INDEX_WIDTH-1:0]          cfg_rdata
`endif
);

   localparam int KIW        = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
   localparam int SIW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   // the last stage never needs the key, so only NUM_STAGES-1 copies are carried
   localparam int KEY_STAGES = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;
   localparam int KSW        = (KEY_STAGES > 1) ? $clog2(KEY_STAGES) : 1;

   typedef logic [KEY_WIDTH-1:0]                                  key_t;
   typedef logic [NUM_HASH-1:0][INDEX_WIDTH-1:0]                  hash_t;
   typedef logic [NUM_HASH-1:0][KEY_WIDTH-1:0][INDEX_WIDTH-1:0]   qmat_t;

   logic [NUM_STAGES-1:0]                                vld_q, vld_d;
   logic [NUM_STAGES-1:0][NUM_HASH-1:0][INDEX_WIDTH-1:0] hash_q, hash_d;
   logic [KEY_STAGES-1:0][KEY_WIDTH-1:0]                 key_q, key_d;
   qmat_t                                                q_q, q_d;

   logic        adv;
   logic        accept;
   logic        cfg_wr_en;
   logic [31:0] cfg_hash_ext;
   logic [31:0] cfg_bit_ext;

   // XOR the Q rows of the key bits owned by stage s into the running partial hash
   function automatic hash_t fold(input key_t k, input hash_t p, input qmat_t q, input int s);
      hash_t r;
      r = p;
      for (int h = 0; h < NUM_HASH; h++) begin
         for (int b = 0; b < BITS_PER_STAGE; b++) begin
            if (k[KIW'(s*BITS_PER_STAGE + b)]) begin
               r[HASH_AW'(h)] = r[HASH_AW'(h)] ^ q[HASH_AW'(h)][KIW'(s*BITS_PER_STAGE + b)];
            end
         end
      end
      return r;
   endfunction

   assign adv          = !vld_q[NUM_STAGES-1] || out_ready;
   assign in_ready     = rst_n && adv;
   assign accept       = in_valid && in_ready;
   // writes only when nothing is in flight, so every key sees one Q snapshot
   assign cfg_ready    = rst_n && (vld_q == '0) && !accept;
   assign cfg_wr_en    = cfg_we && cfg_ready;
   assign cfg_hash_ext = 32'(cfg_hash);
   assign cfg_bit_ext  = 32'(cfg_bit);

   assign out_valid    = vld_q[NUM_STAGES-1];
   assign out_hash     = hash_q[NUM_STAGES-1];

   // stage shift: all stages move together on advance, a missing input becomes a bubble
   always_comb begin
      vld_d  = vld_q;
      hash_d = hash_q;
      key_d  = key_q;
      if (adv) begin
         vld_d[0]  = in_valid;
         hash_d[0] = fold(in_key, '0, q_q, 0);
         key_d[0]  = in_key;
         for (int s = 1; s < NUM_STAGES; s++) begin
            vld_d[SIW'(s)]  = vld_q[SIW'(s-1)];
            hash_d[SIW'(s)] = fold(key_q[KSW'(s-1)], hash_q[SIW'(s-1)], q_q, s);
         end
         for (int s = 1; s < KEY_STAGES; s++) begin
            key_d[KSW'(s)] = key_q[KSW'(s-1)];
         end
      end
   end

   // Q row write; out-of-range hash or bit address matches no row
   always_comb begin
      q_d = q_q;
      for (int h = 0; h < NUM_HASH; h++) begin
         for (int i = 0; i < KEY_WIDTH; i++) begin
            if (cfg_wr_en && cfg_hash_ext == 32'(h) && cfg_bit_ext == 32'(i)) begin
               q_d[HASH_AW'(h)][KIW'(i)] = cfg_wdata;
            end
         end
      end
   end

   // state registers with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q  <= '0;
         hash_q <= '0;
         key_q  <= '0;
         q_q    <= '0;
      end else begin
         vld_q  <= vld_d;
         hash_q <= hash_d;
         key_q  <= key_d;
         q_q    <= q_d;
      end
   end

`ifdef H3_HASH_CFG_READBACK_EN
   logic [INDEX_WIDTH-1:0] rdata_q, rdata_d, rd_lookup;

   // readback mux, captured on cfg_re and held until the next read
   always_comb begin
      rd_lookup = '0;
      for (int h = 0; h < NUM_HASH; h++) begin
         for (int i = 0; i < KEY_WIDTH; i++) begin
            if (cfg_hash_ext == 32'(h) && cfg_bit_ext == 32'(i)) begin
               rd_lookup = q_q[HASH_AW'(h)][KIW'(i)];
            end
         end
      end
      rdata_d = cfg_re ? rd_lookup : rdata_q;
   end

   // readback register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign cfg_rdata = rdata_q;
`endif

endmodule
